// File: rtl/noc_pkg.sv
// Shared NoC router definitions: crossbar select codes and allocator state encoding.
package noc_pkg;

   localparam logic [2:0] CS_N    = 3'd0;
   localparam logic [2:0] CS_S    = 3'd1;
   localparam logic [2:0] CS_W    = 3'd2;
   localparam logic [2:0] CS_E    = 3'd3;
   localparam logic [2:0] CS_L    = 3'd4;
   localparam logic [2:0] CS_NONE = 3'b111;

   typedef enum logic [1:0] {
      ALLOC_IDLE,
      ALLOC_ACTIVE,
      ALLOC_RELEASE
   } alloc_state_t;

endpackage

// File: rtl/w_credit_counter.sv
// Downstream credit tracker: starts full, -1 per sent flit, +1 per returned slot.
// A return while already full is an overflow; the count holds and err latches.
module w_credit_counter #(
   parameter  int CREDIT_DEPTH = 4,
   localparam int CNT_W        = $clog2(CREDIT_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dec_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             nonzero_o,
   output logic             err_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDIT_DEPTH);

   logic [CNT_W-1:0] cnt;
   logic             err;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= CNT_MAX;
         err <= 1'b0;
      end else if (dec_i && !inc_i) begin
         cnt <= cnt - CNT_W'(1);
      end else if (inc_i && !dec_i) begin
         if (cnt == CNT_MAX) err <= 1'b1;
         else                cnt <= cnt + CNT_W'(1);
      end
   end

   assign cnt_o     = cnt;
   assign nonzero_o = (cnt != '0);
   assign err_o     = err;

endmodule

// File: rtl/w_output_allocator.sv
// West output allocator: locks the west output to the RR winner for a whole
// wormhole packet, drives crossbar select/pops, and rotates the RR order after each tail.
//
// state         | meaning
// ALLOC_IDLE    | no owner; waiting for a consistent grant with a pending request
// ALLOC_ACTIVE  | owner holds the output; a flit moves whenever owner req && credit
// ALLOC_RELEASE | tail sent; pulse change_order and drop ownership
module w_output_allocator
   import noc_pkg::*;
#(
   parameter  int CREDIT_DEPTH = 4,
   localparam int CNT_W        = $clog2(CREDIT_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       rrp_w_priority_to_cs_i,
   input  logic             rrp_w_priority_n_i,
   input  logic             rrp_w_priority_s_i,
   input  logic             rrp_w_priority_w_i,
   input  logic             rrp_w_priority_e_i,
   input  logic             rrp_w_priority_l_i,
   input  logic             n_req_i,
   input  logic             s_req_i,
   input  logic             e_req_i,
   input  logic             l_req_i,
   input  logic             n_tail_i,
   input  logic             s_tail_i,
   input  logic             e_tail_i,
   input  logic             l_tail_i,
   input  logic             credit_return_i,
   output logic [2:0]       w_cs_sel_o,
   output logic             w_cs_valid_o,
   output logic             n_pop_o,
   output logic             s_pop_o,
   output logic             e_pop_o,
   output logic             l_pop_o,
   output logic             rr_register_change_order_o,
   output logic             w_busy_o,
   output logic [CNT_W-1:0] credit_cnt_o,
   output logic             credit_err_o
);

   alloc_state_t state, state_nxt;
   logic [2:0]   owner, owner_nxt;
   logic [3:0]   hot;
   logic         grant_ok;
   logic         owner_req, owner_tail;
   logic         credit_nonzero;
   logic         xfer;
   logic         unused_prio_w;

   // A west-to-west grant would be a U-turn, so that line never takes part.
   assign unused_prio_w = rrp_w_priority_w_i;

   assign hot = {rrp_w_priority_l_i, rrp_w_priority_e_i, rrp_w_priority_s_i, rrp_w_priority_n_i};

   always_comb begin
      grant_ok = 1'b0;
      case (rrp_w_priority_to_cs_i)
         CS_N:    grant_ok = (hot == 4'b0001) && n_req_i;
         CS_S:    grant_ok = (hot == 4'b0010) && s_req_i;
         CS_E:    grant_ok = (hot == 4'b0100) && e_req_i;
         CS_L:    grant_ok = (hot == 4'b1000) && l_req_i;
         default: grant_ok = 1'b0;
      endcase
   end

   always_comb begin
      owner_req  = 1'b0;
      owner_tail = 1'b0;
      case (owner)
         CS_N: begin owner_req = n_req_i; owner_tail = n_tail_i; end
         CS_S: begin owner_req = s_req_i; owner_tail = s_tail_i; end
         CS_E: begin owner_req = e_req_i; owner_tail = e_tail_i; end
         CS_L: begin owner_req = l_req_i; owner_tail = l_tail_i; end
         default: begin owner_req = 1'b0; owner_tail = 1'b0; end
      endcase
   end

   assign xfer = (state == ALLOC_ACTIVE) && owner_req && credit_nonzero;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ALLOC_IDLE;
         owner <= CS_NONE;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
      end
   end

   always_comb begin
      state_nxt                  = state;
      owner_nxt                  = owner;
      rr_register_change_order_o = 1'b0;
      case (state)
         ALLOC_IDLE: begin
            if (grant_ok) begin
               owner_nxt = rrp_w_priority_to_cs_i;
               state_nxt = ALLOC_ACTIVE;
            end
         end
         ALLOC_ACTIVE: begin
            if (xfer && owner_tail) state_nxt = ALLOC_RELEASE;
         end
         ALLOC_RELEASE: begin
            rr_register_change_order_o = 1'b1;
            owner_nxt                  = CS_NONE;
            state_nxt                  = ALLOC_IDLE;
         end
         default: begin
            owner_nxt = CS_NONE;
            state_nxt = ALLOC_IDLE;
         end
      endcase
   end

   assign n_pop_o      = xfer && (owner == CS_N);
   assign s_pop_o      = xfer && (owner == CS_S);
   assign e_pop_o      = xfer && (owner == CS_E);
   assign l_pop_o      = xfer && (owner == CS_L);
   assign w_cs_valid_o = xfer;
   assign w_cs_sel_o   = (state == ALLOC_IDLE) ? CS_NONE : owner;
   assign w_busy_o     = (state != ALLOC_IDLE);

   w_credit_counter #(
      .CREDIT_DEPTH(CREDIT_DEPTH)
   ) u_credit (
      .clk       (clk),
      .reset     (reset),
      .dec_i     (xfer),
      .inc_i     (credit_return_i),
      .cnt_o     (credit_cnt_o),
      .nonzero_o (credit_nonzero),
      .err_o     (credit_err_o)
   );

endmodule

// File: tb/tb_w_output_allocator.sv
// Directed bench for w_output_allocator: grants, wormhole locking, credit stalls,
// credit overflow and mid-packet reset, with hand-computed expectations.
module tb_w_output_allocator;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] to_cs = 3'd0;
   logic       pri_n = 0, pri_s = 0, pri_w = 0, pri_e = 0, pri_l = 0;
   logic       n_req = 0, s_req = 0, e_req = 0, l_req = 0;
   logic       n_tail = 0, s_tail = 0, e_tail = 0, l_tail = 0;
   logic       credit_return = 0;
   logic [2:0] sel;
   logic       valid, n_pop, s_pop, e_pop, l_pop, change, busy, err;
   logic [2:0] credit;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   w_output_allocator #(.CREDIT_DEPTH(4)) dut (
      .clk                        (clk),
      .reset                      (reset),
      .rrp_w_priority_to_cs_i     (to_cs),
      .rrp_w_priority_n_i         (pri_n),
      .rrp_w_priority_s_i         (pri_s),
      .rrp_w_priority_w_i         (pri_w),
      .rrp_w_priority_e_i         (pri_e),
      .rrp_w_priority_l_i         (pri_l),
      .n_req_i                    (n_req),
      .s_req_i                    (s_req),
      .e_req_i                    (e_req),
      .l_req_i                    (l_req),
      .n_tail_i                   (n_tail),
      .s_tail_i                   (s_tail),
      .e_tail_i                   (e_tail),
      .l_tail_i                   (l_tail),
      .credit_return_i            (credit_return),
      .w_cs_sel_o                 (sel),
      .w_cs_valid_o               (valid),
      .n_pop_o                    (n_pop),
      .s_pop_o                    (s_pop),
      .e_pop_o                    (e_pop),
      .l_pop_o                    (l_pop),
      .rr_register_change_order_o (change),
      .w_busy_o                   (busy),
      .credit_cnt_o               (credit),
      .credit_err_o               (err)
   );

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are changed and outputs sampled 1-2 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clr_in();
      to_cs = 3'd0;
      pri_n = 0; pri_s = 0; pri_w = 0; pri_e = 0; pri_l = 0;
      n_req = 0; s_req = 0; e_req = 0; l_req = 0;
      n_tail = 0; s_tail = 0; e_tail = 0; l_tail = 0;
      credit_return = 0;
   endtask

   function automatic logic [3:0] pops();
      return {n_pop, s_pop, e_pop, l_pop};
   endfunction

   initial begin
      // 1: reset state
      clr_in();
      reset = 0;
      tick(); tick();
      reset = 1;
      settle();
      chk_val("rst_sel", sel, 3'd7);
      chk_val("rst_credit", credit, 4);
      chk_val("rst_busy", busy, 0);
      chk_val("rst_pops", pops(), 4'b0000);
      chk_val("rst_change", change, 0);
      chk_val("rst_err", err, 0);

      // 2: single-flit L packet
      pri_l = 1; to_cs = 3'd4; l_req = 1; l_tail = 1;
      settle();
      chk_val("l_grant_pops", pops(), 4'b0000);
      tick();
      pri_l = 0;
      settle();
      chk_val("l_c1_pops", pops(), 4'b0001);
      chk_val("l_c1_valid", valid, 1);
      chk_val("l_c1_sel", sel, 3'd4);
      tick();
      l_req = 0; l_tail = 0;
      settle();
      chk_val("l_c2_change", change, 1);
      chk_val("l_c2_sel", sel, 3'd4);
      chk_val("l_c2_credit", credit, 3);
      chk_val("l_c2_pops", pops(), 4'b0000);
      tick();
      chk_val("l_c3_busy", busy, 0);
      chk_val("l_c3_sel", sel, 3'd7);
      chk_val("l_c3_change", change, 0);

      // invalid grants leave the allocator idle
      pri_n = 1; pri_s = 1; to_cs = 3'd0; n_req = 1; s_req = 1;
      tick();
      chk_val("inv_multi_busy", busy, 0);
      clr_in(); pri_e = 1; to_cs = 3'd1; e_req = 1;
      tick();
      chk_val("inv_mismatch_busy", busy, 0);
      clr_in(); pri_n = 1; to_cs = 3'd0;
      tick();
      chk_val("inv_noreq_busy", busy, 0);
      clr_in(); pri_w = 1; to_cs = 3'd2; n_req = 1; s_req = 1; e_req = 1; l_req = 1;
      tick();
      chk_val("inv_west_busy", busy, 0);
      chk_val("inv_credit", credit, 3);

      // single-flit S packet; the W priority line must not spoil the grant
      clr_in(); pri_s = 1; pri_w = 1; to_cs = 3'd1; s_req = 1; s_tail = 1;
      tick();
      pri_s = 0; pri_w = 0;
      settle();
      chk_val("s1_pops", pops(), 4'b0100);
      tick();
      clr_in();
      settle();
      chk_val("s1_change", change, 1);
      tick();
      chk_val("s1_credit", credit, 2);

      // 3: N 3-flit packet, credit runs out before the tail
      pri_n = 1; to_cs = 3'd0; n_req = 1;
      tick();
      pri_n = 0;
      settle();
      chk_val("n_f1_pops", pops(), 4'b1000);
      chk_val("n_f1_credit", credit, 2);
      tick();
      chk_val("n_f2_pops", pops(), 4'b1000);
      chk_val("n_f2_credit", credit, 1);
      tick();
      n_tail = 1;
      settle();
      chk_val("n_stall_credit", credit, 0);
      chk_val("n_stall_pops", pops(), 4'b0000);
      chk_val("n_stall_valid", valid, 0);
      chk_val("n_stall_busy", busy, 1);
      chk_val("n_stall_sel", sel, 3'd0);
      tick();
      credit_return = 1;
      settle();
      chk_val("n_k_pops", pops(), 4'b0000);
      tick();
      credit_return = 0;
      settle();
      chk_val("n_k1_credit", credit, 1);
      chk_val("n_k1_pops", pops(), 4'b1000);
      chk_val("n_k1_valid", valid, 1);
      tick();
      n_req = 0; n_tail = 0;
      settle();
      chk_val("n_k2_change", change, 1);
      chk_val("n_k2_credit", credit, 0);
      tick();
      credit_return = 1;
      tick(); tick();
      credit_return = 0;
      settle();
      chk_val("refill_credit", credit, 2);

      // 4+5: E packet with simultaneous xfer/return, then an E stall while S is offered
      pri_e = 1; to_cs = 3'd3; e_req = 1;
      tick();
      pri_e = 0; credit_return = 1;
      settle();
      chk_val("e_f1_pops", pops(), 4'b0010);
      tick();
      credit_return = 0; e_req = 0;
      pri_s = 1; to_cs = 3'd1; s_req = 1;
      settle();
      chk_val("e_both_credit", credit, 2);
      for (int i = 0; i < 3; i++) begin
         chk_val("e_stall_pops", pops(), 4'b0000);
         chk_val("e_stall_sel", sel, 3'd3);
         chk_val("e_stall_busy", busy, 1);
         tick();
      end
      clr_in(); e_req = 1; e_tail = 1;
      settle();
      chk_val("e_resume_pops", pops(), 4'b0010);
      chk_val("e_resume_credit", credit, 2);
      tick();
      clr_in();
      pri_s = 1; to_cs = 3'd1; s_req = 1; credit_return = 1;
      settle();
      chk_val("e_rel_change", change, 1);
      chk_val("e_rel_credit", credit, 1);
      tick();
      chk_val("rel_grant_ignored", busy, 0);
      tick();
      pri_s = 0; credit_return = 0;
      settle();
      chk_val("s4_f1_busy", busy, 1);
      chk_val("s4_f1_pops", pops(), 4'b0100);
      chk_val("s4_f1_credit", credit, 3);
      tick();
      chk_val("s4_f2_pops", pops(), 4'b0100);

      // 6: reset mid-packet after 2 of 4 S flits
      tick();
      reset = 0;
      tick();
      reset = 1;
      settle();
      chk_val("mid_rst_busy", busy, 0);
      chk_val("mid_rst_sel", sel, 3'd7);
      chk_val("mid_rst_credit", credit, 4);
      chk_val("mid_rst_change", change, 0);
      chk_val("mid_rst_pops", pops(), 4'b0000);
      tick();
      chk_val("mid_rst_change2", change, 0);
      chk_val("mid_rst_busy2", busy, 0);

      // credit overflow while full is sticky until reset
      clr_in(); credit_return = 1;
      tick();
      credit_return = 0;
      settle();
      chk_val("ovf_credit", credit, 4);
      chk_val("ovf_err", err, 1);
      tick(); tick();
      chk_val("ovf_err_sticky", err, 1);
      reset = 0;
      tick();
      reset = 1;
      settle();
      chk_val("ovf_err_clear", err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/w_output_allocator.md
Name: w_output_allocator

Overview:
Downstream companion of the west round-robin processor. It consumes the processor's one-hot grant and crossbar-select code and locks the west output to the winning input for a whole wormhole packet. It drives the crossbar select and per-input pop strobes, and tracks downstream buffer credits. After each tail flit it pulses rr_register_change_order so the round-robin order rotates before the next arbitration.

Parameters:
CREDIT_DEPTH, 4, flit slots in the downstream (west neighbour) input buffer; initial and maximum credit count
CNT_W, $clog2(CREDIT_DEPTH+1), credit counter width (derived; not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset
rrp_w_priority_to_cs_i  input  3  encoded winner from the west RR processor (N=0,S=1,W=2,E=3,L=4)
rrp_w_priority_n_i / _s_i / _w_i / _e_i / _l_i  input  1 each  one-hot winner from the RR processor; _w_i is always ignored (no U-turn)
n_req_i / s_req_i / e_req_i / l_req_i  input  1 each  input port holds a valid head-of-queue flit routed west
n_tail_i / s_tail_i / e_tail_i / l_tail_i  input  1 each  that head flit is a tail (a head+tail flit is a single-flit packet)
credit_return_i  input  1  downstream freed one slot this cycle
w_cs_sel_o  output  3  crossbar select for the west output; 3'b111 = none
w_cs_valid_o  output  1  a flit crosses the switch this cycle
n_pop_o / s_pop_o / e_pop_o / l_pop_o  output  1 each  dequeue the head flit of that input
rr_register_change_order_o  output  1  one-cycle pulse that rotates the RR registers
w_busy_o  output  1  output is locked to an owner (state != IDLE)
credit_cnt_o  output  CNT_W  current credit count
credit_err_o  output  1  sticky overflow flag

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, owner=CS_NONE (3'b111), credit=CREDIT_DEPTH, credit_err=0.
  - All pops, w_cs_valid_o and rr_register_change_order_o are 0; w_cs_sel_o=3'b111.
  - Reset asserted mid-packet aborts the packet; no change_order pulse is issued.
- FSM states: IDLE, ACTIVE, RELEASE.
- IDLE:
  - A grant is valid when exactly one of priority_n/s/e/l is 1, to_cs_i matches that port's code, and that port's req_i is 1.
  - Valid grant: owner<=to_cs_i and state<=ACTIVE at the next edge. Grant-to-first-pop latency is 1 cycle.
  - Invalid grant (zero or multiple hot, mismatch, no req): stay IDLE, no effect.
- ACTIVE:
  - xfer = owner's req_i && credit!=0, combinational.
  - On xfer: that port's pop_o=1, w_cs_valid_o=1, w_cs_sel_o=owner.
  - xfer with owner's tail_i=1: state<=RELEASE.
  - Owner req low or credit==0: stall with ownership held. New grants for other ports are ignored and no other pop is issued.
- RELEASE:
  - rr_register_change_order_o=1 for exactly this cycle; owner<=CS_NONE; state<=IDLE.
  - Grant inputs are ignored this cycle, so the next grant cannot come earlier than 1 cycle after the pulse.
- w_cs_sel_o = owner in ACTIVE and RELEASE, 3'b111 in IDLE.
- w_busy_o = (state!=IDLE).
- Credit counter:
  - xfer only: -1.
  - credit_return_i only: +1.
  - Both in the same cycle: unchanged.
  - credit_return_i at CREDIT_DEPTH without xfer: count holds and credit_err<=1, sticky until reset.
  - Decrement below 0 cannot occur because xfer requires credit!=0.
- The single-flit packet path is IDLE -> ACTIVE -> RELEASE -> IDLE: 3 cycles minimum per packet.

Decomposition:
- Shared noc_pkg (extend it):
  - CS_N=3'd0, CS_S=3'd1, CS_W=3'd2, CS_E=3'd3, CS_L=3'd4, CS_NONE=3'b111.
  - typedef enum logic [1:0] {ALLOC_IDLE, ALLOC_ACTIVE, ALLOC_RELEASE} alloc_state_t.
- One sub-module, w_credit_counter (params CREDIT_DEPTH; ports clk, reset, dec_i, inc_i, cnt_o, nonzero_o, err_o).
- N/S/E allocators reuse it unchanged.

Test Plan:
1. Hold reset=0 for 2 cycles, then release -> w_cs_sel_o=3'b111, credit_cnt_o=4, w_busy_o=0, all pops=0, change_order=0.
2. Cycle 0: priority_l=1, to_cs=4, l_req=1, l_tail=1.
   -> Cycle 1: l_pop=1, w_cs_valid=1, sel=4, credit 4->3.
   -> Cycle 2: change_order=1, sel=4.
   -> Cycle 3: busy=0, sel=7.
3. Cycle 0: N 3-flit packet granted (to_cs=0) with credit preset to 2, no returns.
   -> Flits 1 and 2 pop; flit 3 stalls at credit=0.
   -> credit_return at cycle k: credit=1 at k+1, n_pop=1 at k+1.
   -> change_order=1 at k+2.
4. Credit=2, ACTIVE xfer and credit_return_i in the same cycle -> credit stays 2.
   - Separately, credit_return_i at 4 while IDLE -> credit stays 4, credit_err_o=1, and stays 1 until reset.
5. E owns output, e_req drops for 3 cycles while priority_s=1, to_cs=1, s_req=1 -> s_pop=0 and sel=3 throughout; E resumes when e_req returns.
6. Reset=0 asserted mid-packet (after 2 of 4 S flits) -> next cycle IDLE, sel=7, credit=4, change_order never pulses.
